sort_port_arbiter: RTL

- Shares the single host port of the 8x8-bit selection-sort unit between N_REQ requesters.
- Round-robin grant, one transaction at a time. Each transaction is READ, WRITE or SORT.
- Sequences the sorter's start/ready handshake and returns read data to the winning requester.
- Sits between client blocks and the sort unit (the `circuit` top-level port).

---
 rtl/sort_port_arbiter_pkg.sv | 23 ++
 rtl/sort_port_arbiter_if.sv | 50 +++++
 rtl/sort_port_arbiter_rr_picker.sv | 31 +++
 rtl/sort_port_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/sort_port_arbiter_pkg.sv
// Shared types for the sort-unit port arbiter: command/state encodings and
// default sorter bus widths.
package sort_arb_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    CMD_READ  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_SORT  = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    RWAIT = 3'd2,
    SWAIT = 3'd3,
    ACK   = 3'd4
  } state_t;

endpackage

// File: rtl/sort_port_arbiter_if.sv
// Client-side and sorter-side bus of the sort port arbiter.
// Optional lock vector is present only when SORT_ARB_LOCK_EN is defined.
interface sort_port_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW    = sort_arb_pkg::AW_DEF,
  parameter int DW    = sort_arb_pkg::DW_DEF
);
  import sort_arb_pkg::*;

  // Handshake: a client raises req[i] (level) with cmd/addr/wdata held stable;
  // req is only sampled while the arbiter is idle, gnt[i] marks the owner and
  // ack[i] pulses for one cycle on completion, with rdata valid in that cycle.
  // Lowering req in the cycle after ack ends the request; keeping it high
  // starts a new transaction.
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0][1:0]    cmd;
  logic [N_REQ-1:0][AW-1:0] addr;
  logic [N_REQ-1:0][DW-1:0] wdata;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         ack;
  logic [DW-1:0]            rdata;
  logic                     busy;
  logic                     s_start;
  logic                     s_wr;
  logic [AW-1:0]            s_addr;
  logic [DW-1:0]            s_datain;
  logic [DW-1:0]            s_dataout;
  logic                     s_ready;
  state_t                   state;
`ifdef SORT_ARB_LOCK_EN
  logic [N_REQ-1:0]         lock;
`endif

  modport slave (
`ifdef SORT_ARB_LOCK_EN
    input  lock,
`endif
    input  req, cmd, addr, wdata, s_dataout, s_ready,
    output gnt, ack, rdata, busy, s_start, s_wr, s_addr, s_datain, state
  );

  modport master (
`ifdef SORT_ARB_LOCK_EN
    output lock,
`endif
    output req, cmd, addr, wdata, s_dataout, s_ready,
    input  gnt, ack, rdata, busy, s_start, s_wr, s_addr, s_datain, state
  );

endinterface

// File: rtl/sort_port_arbiter_rr_picker.sv
// Combinational rotating-priority select: searches from ptr_i+1 upward,
// wrapping, so ptr_i itself has the lowest priority.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IW-1:0]    idx_o,
  output logic             vld_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_oh_o = '0;
    idx_o    = '0;
    vld_o    = 1'b0;
    cand     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(ptr_i) + i) % N_REQ);
      if (!vld_o && req_i[cand]) begin
        vld_o    = 1'b1;
        idx_o    = cand;
        gnt_oh_o = N_REQ'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/sort_port_arbiter.sv
// Round-robin arbiter sharing the single sorter host port between N_REQ clients.
// Define SORT_ARB_LOCK_EN to add the per-client lock input for multi-op ownership.
module sort_port_arbiter
  import sort_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input logic               clk,
  input logic               nrst,
  sort_port_arbiter_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state_q;
  cmd_t             cmd_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    win_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] ack_q;
  logic [DW-1:0]    rdata_q;
  logic             busy_q;
  logic             s_start_q;
  logic             s_wr_q;
  logic [AW-1:0]    s_addr_q;
  logic [DW-1:0]    s_datain_q;
  logic             seen_busy_q;

  logic [N_REQ-1:0] req_elig;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  cmd_t             pick_cmd;
  logic             enter_ack;

`ifdef SORT_ARB_LOCK_EN
  logic             lock_vld_q;
  logic [IW-1:0]    lock_own_q;

  // While a client holds the lock, nobody else is even considered.
  always_comb begin
    req_elig = bus.req;
    if (lock_vld_q) req_elig = bus.req & (N_REQ'(1) << lock_own_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
    end else if (enter_ack) begin
      lock_vld_q <= bus.lock[win_q];
      lock_own_q <= win_q;
    end
  end
`else
  always_comb req_elig = bus.req;
`endif

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req_i   (req_elig),
    .ptr_i   (ptr_q),
    .gnt_oh_o(pick_oh),
    .idx_o   (pick_idx),
    .vld_o   (pick_vld)
  );

  assign pick_cmd = cmd_t'(bus.cmd[pick_idx]);

  always_comb begin
    enter_ack = 1'b0;
    case (state_q)
      ISSUE:   enter_ack = (cmd_q == CMD_WRITE) || (cmd_q == CMD_RSVD);
      RWAIT:   enter_ack = 1'b1;
      SWAIT:   enter_ack = seen_busy_q && bus.s_ready;
      default: enter_ack = 1'b0;
    endcase
  end

  // Sorter strobes are set on the edge entering ISSUE so they are registered
  // and high for exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cmd_q       <= CMD_READ;
      ptr_q       <= IW'(N_REQ - 1);
      win_q       <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      s_start_q   <= 1'b0;
      s_wr_q      <= 1'b0;
      s_addr_q    <= '0;
      s_datain_q  <= '0;
      seen_busy_q <= 1'b0;
    end else begin
      ack_q     <= '0;
      s_start_q <= 1'b0;
      s_wr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.s_ready && pick_vld) begin
            win_q   <= pick_idx;
            ptr_q   <= pick_idx;
            gnt_q   <= pick_oh;
            cmd_q   <= pick_cmd;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
            case (pick_cmd)
              CMD_WRITE: begin
                s_wr_q     <= 1'b1;
                s_addr_q   <= bus.addr[pick_idx];
                s_datain_q <= bus.wdata[pick_idx];
              end
              CMD_READ: s_addr_q  <= bus.addr[pick_idx];
              CMD_SORT: s_start_q <= 1'b1;
              default:  ;
            endcase
          end
        end
        ISSUE: begin
          if (cmd_q == CMD_READ) begin
            state_q <= RWAIT;
          end else if (cmd_q == CMD_SORT) begin
            seen_busy_q <= 1'b0;
            state_q     <= SWAIT;
          end
        end
        RWAIT: rdata_q <= bus.s_dataout;
        SWAIT: begin
          // Completion only counts once the sorter has been seen busy.
          if (!bus.s_ready) seen_busy_q <= 1'b1;
        end
        ACK: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (enter_ack) begin
        ack_q   <= gnt_q;
        state_q <= ACK;
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.s_start  = s_start_q;
  assign bus.s_wr     = s_wr_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_datain = s_datain_q;
  assign bus.state    = state_q;

endmodule
